// File: rtl/video_rx.sv
// video_rx: DE/sync video receiver producing pixel coordinates and frame lock; define VIDEO_RX_CHECK_EN for line/frame timing checks
module video_rx #(
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic                      pixel_clk,
  input  logic                      pixel_rst,
  input  logic                      vid_hs,
  input  logic                      vid_vs,
  input  logic                      vid_blank,
  input  logic [23:0]               vid_rgb,
  output logic                      pix_valid,
  output logic [23:0]               pix_rgb,
  output logic [$clog2(HDISP)-1:0]  pix_x,
  output logic [$clog2(VDISP)-1:0]  pix_y,
  output logic                      sof,
  output logic                      eol,
  output logic                      locked,
  output logic                      err_line,
  output logic                      err_frame
);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int CW = $clog2(HDISP + 1);
  localparam int LW = $clog2(VDISP + 1);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCK} state_t;
  state_t st, nxt;
  logic hs_r, vs_r, vs_q, blank_r, blank_q;
  logic [23:0] rgb_r, rgb_d;
  logic [CW-1:0] cnt;
  logic [LW-1:0] ln, ln_inc;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic arm, act, vs_fall, blank_fall, line_err, frame_err, valid_d, sof_d, eol_d;
  assign act = st != SEARCH;
  assign vs_fall = vs_q && !vs_r;
  assign blank_fall = blank_q && !blank_r;
  assign ln_inc = ln == LW'(VDISP) ? ln : ln + 1'b1;
`ifdef VIDEO_RX_CHECK_EN
  logic bad, good;
  assign line_err = act && ((blank_fall && cnt != CW'(HDISP)) || (!hs_r && blank_r));
  // a line closing in the same cycle as the VS edge is counted before the frame is judged
  assign frame_err = act && vs_fall && ((blank_fall ? ln_inc : ln) != LW'(VDISP));
  always_ff @(posedge pixel_clk)
    if (pixel_rst) begin
      bad <= 1'b0;
      good <= 1'b0;
    end else begin
      bad <= act && !vs_fall && (bad || line_err);
      good <= (st == ACQUIRE && nxt == ACQUIRE) ? (vs_fall ? !(bad || line_err || frame_err) : good) : 1'b0;
    end
  always_comb
    nxt = st == SEARCH ? (vs_fall ? ACQUIRE : SEARCH) :
          (line_err || frame_err) ? ACQUIRE :
          (st == ACQUIRE && vs_fall && !bad && good) ? LOCK : st;
`else
  logic unused_hs;
  assign unused_hs = hs_r;
  assign line_err = 1'b0;
  assign frame_err = 1'b0;
  always_comb nxt = (st == SEARCH && vs_fall) ? LOCK : st;
`endif
  always_ff @(posedge pixel_clk)
    if (pixel_rst) st <= SEARCH;
    else st <= nxt;
  always_comb begin
    valid_d = act && blank_r;
    rgb_d = !act ? '0 : blank_r ? rgb_r : pix_rgb;
    x_d = !act ? '0 : blank_r ? XW'(cnt) : pix_x;
    y_d = !act ? '0 : blank_r ? YW'(ln) : pix_y;
    sof_d = valid_d && arm && cnt == '0 && ln == '0;
    eol_d = valid_d && cnt == CW'(HDISP - 1);
  end
  // sync copies reset high so no spurious falling edge is seen from reset
  always_ff @(posedge pixel_clk)
    if (pixel_rst) begin
      hs_r <= 1'b1;
      vs_r <= 1'b1;
      vs_q <= 1'b1;
      blank_r <= 1'b0;
      blank_q <= 1'b0;
      rgb_r <= '0;
      cnt <= '0;
      ln <= '0;
      arm <= 1'b0;
      pix_valid <= 1'b0;
      pix_rgb <= '0;
      pix_x <= '0;
      pix_y <= '0;
      sof <= 1'b0;
      eol <= 1'b0;
      locked <= 1'b0;
      err_line <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      hs_r <= vid_hs;
      vs_r <= vid_vs;
      vs_q <= vs_r;
      blank_r <= vid_blank;
      blank_q <= blank_r;
      rgb_r <= vid_rgb;
      cnt <= blank_fall ? '0 : (blank_r && cnt != CW'(HDISP)) ? cnt + 1'b1 : cnt;
      ln <= vs_fall ? '0 : blank_fall ? ln_inc : ln;
      arm <= vs_fall ? 1'b1 : blank_r ? 1'b0 : arm;
      pix_valid <= valid_d;
      pix_rgb <= rgb_d;
      pix_x <= x_d;
      pix_y <= y_d;
      sof <= sof_d;
      eol <= eol_d;
      locked <= nxt == LOCK;
      err_line <= line_err;
      err_frame <= frame_err;
    end
endmodule

// File: tb/tb_video_rx.sv
// tb_video_rx: table-driven check of video_rx on a 4x3 raster plus reset and long-line sequences
module tb_video_rx;
  localparam int H = 4;
  localparam int V = 3;
`ifdef VIDEO_RX_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic pixel_clk = 1'b0, pixel_rst = 1'b1, vid_hs = 1'b1, vid_vs = 1'b1, vid_blank = 1'b0;
  logic [23:0] vid_rgb = '0;
  logic pix_valid, sof, eol, locked, err_line, err_frame;
  logic [23:0] pix_rgb;
  logic [1:0] pix_x, pix_y;
  typedef struct {
    logic hs, vs, blank;
    logic [23:0] rgb;
    logic v, s, e, lk, el, ef, cd;
    logic [23:0] xr;
    logic [1:0] x, y;
  } vec_t;
  vec_t tbl[$];
  int tests = 0, fails = 0;

  video_rx #(.HDISP(H), .VDISP(V)) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_blank(vid_blank), .vid_rgb(vid_rgb), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .locked(locked),
    .err_line(err_line), .err_frame(err_frame)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(string t);
    chk({t, " valid"}, 32'(pix_valid), 32'h0);
    chk({t, " rgb"}, 32'(pix_rgb), 32'h0);
    chk({t, " x"}, 32'(pix_x), 32'h0);
    chk({t, " y"}, 32'(pix_y), 32'h0);
    chk({t, " sof"}, 32'(sof), 32'h0);
    chk({t, " eol"}, 32'(eol), 32'h0);
    chk({t, " locked"}, 32'(locked), 32'h0);
    chk({t, " err_line"}, 32'(err_line), 32'h0);
    chk({t, " err_frame"}, 32'(err_frame), 32'h0);
  endtask

  function automatic logic [23:0] pix(int f, int x, int y);
    return (f == 1 && x == 0 && y == 0) ? 24'hFFFFFF : {8'(f), 8'(y), 8'(x)};
  endfunction

  task automatic add(logic hs, vs, blank, logic [23:0] rgb, logic v, s, e, lk, el, ef, cd,
                     logic [23:0] xr, int x, int y);
    vec_t r;
    r.hs = hs; r.vs = vs; r.blank = blank; r.rgb = rgb;
    r.v = v; r.s = s; r.e = e; r.lk = lk; r.el = el; r.ef = ef; r.cd = cd;
    r.xr = xr; r.x = 2'(x); r.y = 2'(y);
    tbl.push_back(r);
  endtask

  // n active pixels then one blanking cycle; on=0 means the receiver is still searching
  task automatic line(int f, int y, int n, logic on, logic lk, logic lk_end, logic el);
    for (int x = 0; x < n; x++) begin
      logic [23:0] c;
      c = pix(f, x, y);
      add(1'b1, 1'b1, 1'b1, c, on, on && x == 0 && y == 0, on && x == H - 1, lk, 1'b0, 1'b0, 1'b1,
          on ? c : 24'h0, on ? x : 0, on ? y : 0);
    end
    add(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, lk_end, el, 1'b0, !on, 24'h0, 0, 0);
  endtask

  task automatic vsync(logic on, logic lk, logic ef);
    add(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, lk, 1'b0, ef, !on, 24'h0, 0, 0);
    add(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, lk, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
  endtask

  task automatic frame(int f, int nl, logic lk, logic lk_end, logic ef);
    for (int y = 0; y < nl; y++) line(f, y, H, 1'b1, lk, lk, 1'b0);
    vsync(1'b1, lk_end, ef);
  endtask

  task automatic drive(logic hs, vs, blank, logic [23:0] rgb);
    vid_hs = hs; vid_vs = vs; vid_blank = blank; vid_rgb = rgb;
  endtask

  task automatic check_row(int i);
    vec_t r;
    string t;
    r = tbl[i];
    t = $sformatf("row%0d", i);
    chk({t, " valid"}, 32'(pix_valid), 32'(r.v));
    chk({t, " sof"}, 32'(sof), 32'(r.s));
    chk({t, " eol"}, 32'(eol), 32'(r.e));
    chk({t, " locked"}, 32'(locked), 32'(r.lk));
    chk({t, " err_line"}, 32'(err_line), 32'(r.el));
    chk({t, " err_frame"}, 32'(err_frame), 32'(r.ef));
    if (r.cd) begin
      chk({t, " rgb"}, 32'(pix_rgb), 32'(r.xr));
      chk({t, " x"}, 32'(pix_x), 32'(r.x));
      chk({t, " y"}, 32'(pix_y), 32'(r.y));
    end
  endtask

  // after step() returns, the outputs belong to the previous step's inputs
  task automatic step(logic hs, vs, blank, logic [23:0] rgb);
    @(negedge pixel_clk);
    drive(hs, vs, blank, rgb);
    @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge pixel_clk);
    chk_zero("reset");
    line(0, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    line(0, 2, H, 1'b0, 1'b0, 1'b0, 1'b0);
    vsync(1'b0, !CHK, 1'b0);
    frame(1, V, !CHK, !CHK, 1'b0);
    frame(2, V, !CHK, 1'b1, 1'b0);
    line(3, 0, H, 1'b1, 1'b1, 1'b1, 1'b0);
    line(3, 1, H - 1, 1'b1, 1'b1, !CHK, CHK);
    line(3, 2, H, 1'b1, !CHK, !CHK, 1'b0);
    vsync(1'b1, !CHK, 1'b0);
    frame(4, V, !CHK, !CHK, 1'b0);
    frame(5, V, !CHK, 1'b1, 1'b0);
    frame(6, V - 1, 1'b1, !CHK, CHK);
    frame(7, V, !CHK, !CHK, 1'b0);
    frame(8, V, !CHK, 1'b1, 1'b0);
    pixel_rst = 1'b0;
    for (int j = 0; j < tbl.size() + 2; j++) begin
      if (j >= 2) check_row(j - 2);
      if (j < tbl.size()) drive(tbl[j].hs, tbl[j].vs, tbl[j].blank, tbl[j].rgb);
      else drive(1'b1, 1'b1, 1'b0, 24'h0);
      @(negedge pixel_clk);
    end
    // HS low during an active pixel, then a line two pixels too long
    step(1'b0, 1'b1, 1'b1, 24'h123456);
    step(1'b1, 1'b1, 1'b1, 24'h22B0B0);
    chk("hs pix sof", 32'(sof), 32'h1);
    chk("hs pix rgb", 32'(pix_rgb), 32'h123456);
    chk("hs pix err_line", 32'(err_line), 32'(CHK));
    step(1'b1, 1'b1, 1'b1, 24'h33C0C0);
    chk("hs next x", 32'(pix_x), 32'h1);
    chk("hs next locked", 32'(locked), 32'(!CHK));
    chk("hs next err_line", 32'(err_line), 32'h0);
    step(1'b1, 1'b1, 1'b1, 24'h44D0D0);
    chk("long x2 eol", 32'(eol), 32'h0);
    step(1'b1, 1'b1, 1'b1, 24'h55E0E0);
    chk("long x3 eol", 32'(eol), 32'h1);
    chk("long x3 x", 32'(pix_x), 32'h3);
    step(1'b1, 1'b1, 1'b1, 24'h66F0F0);
    chk("long x4 eol", 32'(eol), 32'h0);
    chk("long x4 valid", 32'(pix_valid), 32'h1);
    step(1'b1, 1'b1, 1'b0, 24'h0);
    chk("long x5 eol", 32'(eol), 32'h0);
    chk("long x5 rgb", 32'(pix_rgb), 32'h66F0F0);
    step(1'b1, 1'b1, 1'b0, 24'h0);
    chk("blank valid", 32'(pix_valid), 32'h0);
    chk("blank rgb hold", 32'(pix_rgb), 32'h66F0F0);
    // reset in the middle of line 1
    step(1'b1, 1'b1, 1'b1, 24'h0A0A0A);
    step(1'b1, 1'b1, 1'b1, 24'h0B0B0B);
    chk("line1 y", 32'(pix_y), 32'h1);
    chk("line1 rgb", 32'(pix_rgb), 32'h0A0A0A);
    pixel_rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 24'h0C0C0C);
    chk_zero("midrst");
    pixel_rst = 1'b0;
    step(1'b1, 1'b1, 1'b1, 24'h0D0D0D);
    step(1'b1, 1'b1, 1'b1, 24'h0E0E0E);
    chk("search valid", 32'(pix_valid), 32'h0);
    chk("search locked", 32'(locked), 32'h0);
    step(1'b1, 1'b1, 1'b0, 24'h0);
    chk("search valid2", 32'(pix_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b0, 24'h0);
    chk("relock locked", 32'(locked), 32'(!CHK));
    step(1'b1, 1'b1, 1'b1, 24'hABCDEF);
    step(1'b1, 1'b1, 1'b1, 24'h010203);
    chk("relock sof", 32'(sof), 32'h1);
    chk("relock valid", 32'(pix_valid), 32'h1);
    chk("relock rgb", 32'(pix_rgb), 32'hABCDEF);
    chk("relock xy", 32'({pix_x, pix_y}), 32'h0);
    step(1'b1, 1'b1, 1'b0, 24'h0);
    chk("relock x1", 32'(pix_x), 32'h1);
    chk("relock sof1", 32'(sof), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
